// File: rtl/elevador_planificador.sv
// SCAN call scheduler and motion sequencer for a three-floor elevator.
// Latches floor calls, times motor travel per floor and door dwell per stop.
module elevador_planificador #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] llamada,
  output logic       motorsubir,
  output logic       motorbajar,
  output logic       puerta,
  output logic [3:0] piso,
  output logic [2:0] pendientes,
  output logic       ocupado
);

  localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES);
  localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [1:0] {StReposo, StSubiendo, StBajando, StPuerta} state_e;

  state_e          state_q, state_d;
  logic [1:0]      piso_q, piso_d;
  logic [2:0]      pend_q, pend_d;
  logic            dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      2'd2:    return 3'b001;
      2'd3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0] here;
  logic [2:0] latch_mask;
  logic [2:0] clr;
  logic [1:0] nxt_up, nxt_dn;
  logic       any_above, any_below;

  always_comb begin
    state_d    = state_q;
    piso_d     = piso_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    clr        = 3'b000;
    here       = floor_bit(piso_q);
    nxt_up     = piso_q + 2'd1;
    nxt_dn     = piso_q - 2'd1;
    any_above  = |(pend_q & above_mask(piso_q));
    any_below  = |(pend_q & below_mask(piso_q));
    // A call for the open-door floor re-arms the door rather than queueing.
    latch_mask = (state_q == StPuerta) ? here : 3'b000;

    case (state_q)
      StReposo: begin
        if (|(pend_q & here)) begin
          state_d = StPuerta;
          clr     = here;
          cnt_d   = DoorLoad;
        end else if (dir_q) begin
          if (any_above) begin
            state_d = StSubiendo;
            cnt_d   = TravelLoad;
          end else if (any_below) begin
            state_d = StBajando;
            dir_d   = 1'b0;
            cnt_d   = TravelLoad;
          end
        end else begin
          if (any_below) begin
            state_d = StBajando;
            cnt_d   = TravelLoad;
          end else if (any_above) begin
            state_d = StSubiendo;
            dir_d   = 1'b1;
            cnt_d   = TravelLoad;
          end
        end
      end
      StSubiendo: begin
        if (piso_q >= 2'd3 || piso_q == 2'd0) begin
          state_d = StReposo;
        end else if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          piso_d = nxt_up;
          if (|(pend_q & floor_bit(nxt_up))) begin
            state_d = StPuerta;
            clr     = floor_bit(nxt_up);
            cnt_d   = DoorLoad;
          end else if (|(pend_q & above_mask(nxt_up))) begin
            cnt_d = TravelLoad;
          end else begin
            state_d = StReposo;
          end
        end
      end
      StBajando: begin
        if (piso_q <= 2'd1) begin
          state_d = StReposo;
        end else if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          piso_d = nxt_dn;
          if (|(pend_q & floor_bit(nxt_dn))) begin
            state_d = StPuerta;
            clr     = floor_bit(nxt_dn);
            cnt_d   = DoorLoad;
          end else if (|(pend_q & below_mask(nxt_dn))) begin
            cnt_d = TravelLoad;
          end else begin
            state_d = StReposo;
          end
        end
      end
      StPuerta: begin
        if (|(llamada & here)) begin
          cnt_d = DoorLoad;
        end else if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d = StReposo;
        end
      end
      default: state_d = StReposo;
    endcase

    // Clear wins over a same-cycle set of the same bit.
    pend_d = (pend_q | (llamada & ~latch_mask)) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReposo;
      piso_q     <= 2'd1;
      pend_q     <= 3'b000;
      dir_q      <= 1'b1;
      cnt_q      <= '0;
      motorsubir <= 1'b0;
      motorbajar <= 1'b0;
      puerta     <= 1'b0;
    end else begin
      state_q    <= state_d;
      piso_q     <= piso_d;
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      motorsubir <= (state_d == StSubiendo);
      motorbajar <= (state_d == StBajando);
      puerta     <= (state_d == StPuerta);
    end
  end

  assign piso       = {2'b00, piso_q};
  assign pendientes = pend_q;
  assign ocupado    = (state_q != StReposo);

endmodule

// File: tb/tb_elevador_planificador.sv
// Bench for elevador_planificador: directed scenarios with literal expectations
// plus randomized calls/resets checked every cycle against a behavioural model.
module tb_elevador_planificador;

  localparam int Trav = 8;
  localparam int Door = 4;
  localparam int MIdle = 0, MUp = 1, MDown = 2, MDoor = 3;

  logic       clk;
  logic       rst;
  logic [2:0] llamada;
  logic       motorsubir, motorbajar, puerta, ocupado;
  logic [3:0] piso;
  logic [2:0] pendientes;

  int n_total = 0;
  int n_pass  = 0;

  elevador_planificador #(
    .TRAVEL_CYCLES(Trav),
    .DOOR_CYCLES  (Door)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .llamada   (llamada),
    .motorsubir(motorsubir),
    .motorbajar(motorbajar),
    .puerta    (puerta),
    .piso      (piso),
    .pendientes(pendientes),
    .ocupado   (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode;
  int         m_floor;
  int         m_left;
  bit         m_dir_up;
  logic [2:0] m_pend;
  bit         m_valid = 0;

  function automatic bit calls_above(input logic [2:0] p, input int f);
    for (int k = f + 1; k <= 3; k++) if (p[k-1]) return 1;
    return 0;
  endfunction

  function automatic bit calls_below(input logic [2:0] p, input int f);
    for (int k = 1; k < f; k++) if (p[k-1]) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [2:0] old_pend, newcalls;
    bit rearm, up, dn;
    if (rst) begin
      m_mode = MIdle; m_floor = 1; m_pend = 3'b000; m_dir_up = 1; m_left = 0; m_valid = 1;
    end else if (m_valid) begin
      old_pend = m_pend;
      newcalls = llamada;
      rearm    = 0;
      if (m_mode == MDoor && llamada[m_floor-1]) begin
        newcalls[m_floor-1] = 1'b0;
        rearm = 1;
      end
      m_pend = old_pend | newcalls;
      case (m_mode)
        MIdle: begin
          up = calls_above(old_pend, m_floor);
          dn = calls_below(old_pend, m_floor);
          if (old_pend[m_floor-1]) begin
            m_mode = MDoor; m_left = Door; m_pend[m_floor-1] = 1'b0;
          end else if ((m_dir_up && up) || (!m_dir_up && up && !dn)) begin
            m_mode = MUp; m_dir_up = 1; m_left = Trav;
          end else if (dn) begin
            m_mode = MDown; m_dir_up = 0; m_left = Trav;
          end
        end
        MUp, MDown: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = (m_mode == MUp) ? m_floor + 1 : m_floor - 1;
            if (old_pend[m_floor-1]) begin
              m_mode = MDoor; m_left = Door; m_pend[m_floor-1] = 1'b0;
            end else if ((m_mode == MUp) ? calls_above(old_pend, m_floor)
                                         : calls_below(old_pend, m_floor)) begin
              m_left = Trav;
            end else begin
              m_mode = MIdle;
            end
          end
        end
        default: begin
          if (rearm) m_left = Door;
          else begin
            m_left--;
            if (m_left == 0) m_mode = MIdle;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk1("cmp_subir", motorsubir, m_mode == MUp);
      chk1("cmp_bajar", motorbajar, m_mode == MDown);
      chk1("cmp_puerta", puerta, m_mode == MDoor);
      chk1("cmp_ocupado", ocupado, m_mode != MIdle);
      chk4("cmp_piso", piso, 4'(m_floor));
      chk4("cmp_pend", {1'b0, pendientes}, {1'b0, m_pend});
      chk1("cmp_exclusive", (motorsubir & motorbajar) | ((motorsubir | motorbajar) & puerta), 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [2:0] l, input logic r);
    llamada = l;
    rst     = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    llamada = 3'b000;
    @(negedge clk);
    step(3'b000, 1'b1);
    chk4("rst_piso", piso, 4'd1);
    chk4("rst_pend", {1'b0, pendientes}, 4'd0);
    chk1("rst_subir", motorsubir, 1'b0);
    chk1("rst_bajar", motorbajar, 1'b0);
    chk1("rst_puerta", puerta, 1'b0);
    chk1("rst_ocupado", ocupado, 1'b0);

    // Floor 1 to 3
    step(3'b100, 1'b0);
    chk4("t13_latch", {1'b0, pendientes}, 4'b0100);
    for (int i = 1; i <= 21; i++) begin
      step(3'b000, 1'b0);
      chk1("t13_subir", motorsubir, i <= 16);
      chk1("t13_puerta", puerta, i >= 17 && i <= 20);
      chk4("t13_piso", piso, (i < 9) ? 4'd1 : ((i < 17) ? 4'd2 : 4'd3));
    end
    chk1("t13_idle", ocupado, 1'b0);
    chk4("t13_pend", {1'b0, pendientes}, 4'd0);
    chk1("model_idle", m_mode == MIdle, 1'b1);
    chk4("model_floor", 4'(m_floor), 4'd3);

    // Call at current floor with re-arm
    step(3'b000, 1'b1);
    step(3'b001, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step((i == 2) ? 3'b001 : 3'b000, 1'b0);
      chk1("tcur_puerta", puerta, i <= 5);
      chk1("tcur_subir", motorsubir, 1'b0);
      chk1("tcur_bajar", motorbajar, 1'b0);
      if (i == 2) chk4("tcur_nolatch", {1'b0, pendientes}, 4'd0);
    end

    // Intermediate stop at floor 2 on the way to 3
    step(3'b100, 1'b0);
    for (int i = 1; i <= 27; i++) begin
      step((i == 4) ? 3'b010 : 3'b000, 1'b0);
      chk1("tmid_subir", motorsubir, (i <= 8) || (i >= 14 && i <= 21));
      chk1("tmid_puerta", puerta, (i >= 9 && i <= 12) || (i >= 22 && i <= 25));
      chk4("tmid_piso", piso, (i < 9) ? 4'd1 : ((i < 22) ? 4'd2 : 4'd3));
      if (i == 13) chk1("tmid_rest", ocupado, 1'b0);
    end

    // SCAN order from floor 2 with dir up
    step(3'b000, 1'b1);
    step(3'b010, 1'b0);
    for (int i = 1; i <= 13; i++) step(3'b000, 1'b0);
    chk4("tscan_start", piso, 4'd2);
    step(3'b101, 1'b0);
    for (int i = 1; i <= 35; i++) begin
      step(3'b000, 1'b0);
      chk1("tscan_subir", motorsubir, i <= 8);
      chk1("tscan_bajar", motorbajar, i >= 14 && i <= 29);
      chk1("tscan_puerta", puerta, (i >= 9 && i <= 12) || (i >= 30 && i <= 33));
      chk4("tscan_piso", piso, (i < 9) ? 4'd2 : ((i < 22) ? 4'd3 : ((i < 30) ? 4'd2 : 4'd1)));
    end

    // Reset mid-travel
    step(3'b100, 1'b0);
    for (int i = 1; i <= 3; i++) step(3'b000, 1'b0);
    chk1("trst_moving", motorsubir, 1'b1);
    chk4("trst_pendpre", {1'b0, pendientes}, 4'b0100);
    step(3'b000, 1'b1);
    chk1("trst_subir", motorsubir, 1'b0);
    chk4("trst_piso", piso, 4'd1);
    chk4("trst_pend", {1'b0, pendientes}, 4'd0);
    chk1("trst_ocupado", ocupado, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(3'b000, 1'b0);
      chk1("trst_still", ocupado | motorsubir | motorbajar | puerta, 1'b0);
    end

    // Randomized calls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
